// File: rtl/background_index_fetch_if.sv
// Pixel-fetch bus for background_index_fetch: screen position and timing in,
// ROM address out / ROM data in, palette index and scroll offset out.
interface background_index_fetch_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        de;
  logic        frame_start;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  index_out;
  logic        index_valid;
  logic [8:0]  scroll_x;

  modport master (
    output DrawX, DrawY, de, frame_start, rom_q,
    input  rom_addr, index_out, index_valid, scroll_x
  );

  modport slave (
    input  DrawX, DrawY, de, frame_start, rom_q,
    output rom_addr, index_out, index_valid, scroll_x
  );
endinterface

// File: rtl/background_index_fetch.sv
// Background pixel fetch: 2x-downscaled screen-to-image mapping, ROM address
// generation and 3-cycle index pipeline. Horizontal scrolling only with BG_SCROLL_EN.
module background_index_fetch #(
  parameter int         IMG_W       = 320,
  parameter int         IMG_H       = 240,
  parameter int         SCROLL_STEP = 1,
  parameter logic [3:0] BLACK_IDX   = 4'h4
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  background_index_fetch_if.slave     bus
);

  // The visible screen is exactly twice the image in each direction.
  localparam int SCR_W = 2 * IMG_W;
  localparam int SCR_H = 2 * IMG_H;

  logic        v0;
  logic [8:0]  xi;
  logic [8:0]  yi;
  logic [8:0]  xs;
  logic [8:0]  scroll_x_reg;
  logic [16:0] y_base;
  logic [16:0] addr_next;
  logic [16:0] rom_addr_reg;
  logic [2:0]  valid_reg;
  logic [3:0]  index_out_reg;

  assign v0 = bus.de && (32'(bus.DrawX) < SCR_W) && (32'(bus.DrawY) < SCR_H);
  assign xi = bus.DrawX[9:1];
  assign yi = bus.DrawY[9:1];

`ifdef BG_SCROLL_EN
  logic [9:0] scroll_sum;
  logic [9:0] xs_sum;

  assign scroll_sum = {1'b0, scroll_x_reg} + 10'(SCROLL_STEP);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      scroll_x_reg <= '0;
    end else if (bus.frame_start) begin
      scroll_x_reg <= (scroll_sum >= 10'(IMG_W)) ? 9'(scroll_sum - 10'(IMG_W)) : scroll_sum[8:0];
    end
  end

  // Both operands are below IMG_W, so a single conditional subtract wraps.
  assign xs_sum = {1'b0, xi} + {1'b0, scroll_x_reg};
  assign xs     = (xs_sum >= 10'(IMG_W)) ? 9'(xs_sum - 10'(IMG_W)) : xs_sum[8:0];
`else
  logic unused_frame_start;
  localparam int unused_scroll_step = SCROLL_STEP;

  assign unused_frame_start = bus.frame_start;
  assign scroll_x_reg       = '0;
  assign xs                 = xi;
`endif

  generate
    if (IMG_W == 320) begin : g_mul320
      assign y_base = (17'(yi) << 8) + (17'(yi) << 6);
    end else begin : g_mul_const
      assign y_base = 17'(yi) * 17'(IMG_W);
    end
  endgenerate

  assign addr_next = y_base + 17'(xs);

  // Address only advances on qualifying pixels so the ROM stays quiet in blanking.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_reg  <= '0;
      valid_reg     <= '0;
      index_out_reg <= BLACK_IDX;
    end else begin
      if (v0) begin
        rom_addr_reg <= addr_next;
      end
      valid_reg     <= {valid_reg[1:0], v0};
      index_out_reg <= valid_reg[1] ? bus.rom_q : BLACK_IDX;
    end
  end

  assign bus.rom_addr    = rom_addr_reg;
  assign bus.index_out   = index_out_reg;
  assign bus.index_valid = valid_reg[2];
  assign bus.scroll_x    = scroll_x_reg;

endmodule
